aes_192_sched: RTL and testbench
================================

Name: aes_192_sched

Overview:
Request scheduler and result tracker in front of the fully pipelined AES-192 encryption core.
- Arbitrates NREQ requesters round-robin and issues at most one block per cycle into the core.
- The core has no valid or stall, so a valid/ID tag pipe of matching depth tracks each block.
- Results are captured into an output FIFO. Credit-based issue control guarantees no result is lost under response backpressure.

Parameters:
NREQ, 4, number of requesters (2..8)
CORE_LATENCY, 25, cycles from a value presented on core_state/core_key to its ciphertext on core_out
FIFO_DEPTH, 32, output FIFO entries; must be >= 1. Full throughput needs FIFO_DEPTH >= CORE_LATENCY+2.

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester block valid
req_ready  out  NREQ  per-requester accept, at most one bit high
req_state  in  NREQ*128  plaintexts; requester i at [128*i +: 128]
req_key  in  NREQ*192  keys; requester i at [192*i +: 192]
core_state  out  128  registered plaintext to core
core_key  out  192  registered key to core
core_out  in  128  ciphertext from core
rsp_valid  out  1  result available
rsp_ready  in  1  result consumer accept
rsp_data  out  128  ciphertext
rsp_id  out  $clog2(NREQ)  index of the originating requester
busy  out  1  any block in flight or in the FIFO

Behaviour:
- Reset (async assert, sync deassert):
  - req_ready=0, rsp_valid=0, busy=0, core_state=0, core_key=0.
  - Tag pipe cleared, FIFO empty, credit=FIFO_DEPTH, round-robin pointer=0.
- Reset mid-operation: all in-flight and queued results are discarded. Core contents are ignored because no tag is valid.
- Credit counter, width $clog2(FIFO_DEPTH+1):
  - Decrement on issue.
  - Increment on pop (rsp_valid & rsp_ready).
  - Issue and pop in the same cycle leave it unchanged.
  - It is never below 0 and never above FIFO_DEPTH.
- Arbitration:
  - When credit>0, grant the first i with req_valid[i]=1, searching from the pointer upward with wrap.
  - req_ready = one-hot grant, or 0 when credit==0. req_ready may depend combinationally on req_valid.
  - On accept, the pointer moves to the granted index+1 (mod NREQ). With no accept, the pointer holds.
- Issue on edge T (accept):
  - core_state and core_key load the granted requester's data.
  - Tag stage 0 loads {valid=1, id=grant}.
  - With no accept, core_state and core_key hold their values and tag stage 0 loads valid=0.
- Tag pipe: CORE_LATENCY stages, shifting every cycle. While the last stage is valid, core_out and that tag's id are pushed into the FIFO on the next edge.
- Latency: the accept edge at T gives rsp_valid=1 in cycle T+CORE_LATENCY+1 when the FIFO was empty. The FIFO is show-ahead, so rsp_data, rsp_id and rsp_valid come straight from the head entry.
- The FIFO cannot overflow thanks to credits. A push into a full FIFO is an assertion failure; the bench checks for it.
- Simultaneous push and pop: permitted in any state, including with exactly one entry; occupancy is unchanged.
- busy = OR of tag valids | FIFO not empty.
- Ordering: results leave in issue order. rsp_id identifies the owner; no per-requester reordering.

Decomposition:
- Package aes_sched_pkg holds AES_BLOCK_W=128, AES192_KEY_W=192, the CORE_LATENCY default, and the tag struct type {valid, id}.
- One sub-module, aes_sched_fifo: a parameterised show-ahead synchronous FIFO with width 128+$clog2(NREQ), async active-low reset, and full/empty/count outputs.
- The arbiter, credit counter and tag pipe stay in aes_192_sched.

Test Plan:
- Single request, key 000102…1617 and plaintext 00112233445566778899aabbccddeeff from requester 2 → rsp_data=dda97ca4864cdfe06eaf70a0ec0d7191 and rsp_id=2 exactly CORE_LATENCY+1 cycles after accept; busy returns to 0 after the pop.
- All 4 requesters valid continuously, rsp_ready=1 → one accept per cycle; grant order 0,1,2,3,0,…; rsp_id sequence matches with no gaps.
- rsp_ready=0 with all requesters valid → exactly FIFO_DEPTH accepts, then req_ready=0. rsp_ready=1 for 1 cycle → exactly 1 further accept; no overflow assertion fires.
- credit==0 while a pop and a pending request fall in the same cycle → the request is accepted the next cycle and credit stays 0.
- rst_n pulsed low with 10 blocks in flight and 5 queued → rsp_valid=0 immediately; no stale results after release; credit=FIFO_DEPTH.
- Requester 1 only, with req_valid toggling every other cycle → the pointer parks correctly and every valid block is accepted within 1 cycle.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared widths, default core latency and tag pipe entry
// for the AES-192 request scheduler (aes_192_sched and aes_sched_fifo).
package aes_sched_pkg;

  localparam int AES_BLOCK_W      = 128;
  localparam int AES192_KEY_W     = 192;
  localparam int CORE_LATENCY_DEF = 25;
  localparam int TAG_ID_W         = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/aes_sched_fifo.sv
// aes_sched_fifo: show-ahead synchronous FIFO, async active-low reset.
// Ports: clk, rst_n, push/wdata, pop, rdata (head), full, empty, count.
module aes_sched_fifo #(
  parameter  int WIDTH = 130,
  parameter  int DEPTH = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // a pop frees the head slot, so push+pop is legal even when full
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= inc(wptr);
      if (do_pop)  rptr <= inc(rptr);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  ovf_chk: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && full && !pop)
  );

endmodule

// File: rtl/aes_192_sched.sv
// aes_192_sched: round-robin, credit-gated issue into a pipelined AES-192
// core; a tag pipe tracks blocks and results land in a show-ahead FIFO.
module aes_192_sched
  import aes_sched_pkg::*;
#(
  parameter  int NREQ         = 4,
  parameter  int CORE_LATENCY = CORE_LATENCY_DEF,
  parameter  int FIFO_DEPTH   = 32,
  localparam int IDW          = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*AES_BLOCK_W-1:0]  req_state,
  input  logic [NREQ*AES192_KEY_W-1:0] req_key,
  output logic [AES_BLOCK_W-1:0]    core_state,
  output logic [AES192_KEY_W-1:0]   core_key,
  input  logic [AES_BLOCK_W-1:0]    core_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [AES_BLOCK_W-1:0]    rsp_data,
  output logic [IDW-1:0]            rsp_id,
  output logic                      busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = AES_BLOCK_W + IDW;

  logic [CW-1:0]  credit;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gidx;
  logic [IDW-1:0] ptr_nxt;
  logic           found;
  logic           accept;
  logic           push;
  logic           pop;
  logic           tags_busy;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [FW-1:0]  fifo_rdata;

  // stage 0 sits beside core_state; stages 1..N track the core registers
  tag_t tag_q [CORE_LATENCY+1];

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        found = 1'b1;
        gidx  = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign accept    = found && (credit != '0);
  assign req_ready = accept ? (NREQ'(1) << gidx) : '0;
  assign ptr_nxt   = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);

  assign push      = tag_q[CORE_LATENCY].valid;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_rdata[AES_BLOCK_W-1:0];
  assign rsp_id    = fifo_rdata[FW-1 -: IDW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      credit     <= CW'(FIFO_DEPTH);
      core_state <= '0;
      core_key   <= '0;
    end else begin
      if (accept) begin
        rr_ptr     <= ptr_nxt;
        core_state <= req_state[AES_BLOCK_W*gidx +: AES_BLOCK_W];
        core_key   <= req_key[AES192_KEY_W*gidx +: AES192_KEY_W];
      end
      if (accept && !pop)
        credit <= credit - CW'(1);
      else if (pop && !accept)
        credit <= credit + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= CORE_LATENCY; k++)
        tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{valid: accept, id: TAG_ID_W'(gidx)};
      for (int k = 1; k <= CORE_LATENCY; k++)
        tag_q[k] <= tag_q[k-1];
    end
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int k = 0; k <= CORE_LATENCY; k++)
      tags_busy = tags_busy | tag_q[k].valid;
  end

  assign busy = tags_busy | !fifo_empty;

  aes_sched_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({tag_q[CORE_LATENCY].id[IDW-1:0], core_out}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // blocks owned by credits = in flight + queued, never more than depth
  credit_chk: assert property (
    @(posedge clk) disable iff (!rst_n)
    (int'(credit) + int'(fifo_count)) <= FIFO_DEPTH
  );

  id_chk: assert property (
    @(posedge clk) disable iff (!rst_n)
    push |-> (int'(tag_q[CORE_LATENCY].id) < NREQ)
  );

  full_chk: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop)
  );

endmodule

// File: tb/tb_aes_192_sched.sv
// tb_aes_192_sched: directed bench with a queue scoreboard for aes_192_sched.
// A behavioural core model supplies core_out with the configured latency.
module tb_aes_192_sched;

  localparam int NREQ  = 4;
  localparam int L     = 25;
  localparam int DEPTH = 32;

  localparam logic [191:0] KEY =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_state;
  logic [NREQ*192-1:0] req_key;
  logic [127:0]        core_state;
  logic [191:0]        core_key;
  logic [127:0]        core_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [127:0]        rsp_data;
  logic [1:0]          rsp_id;
  logic                busy;

  always #5 clk = ~clk;

  aes_192_sched #(
    .NREQ         (NREQ),
    .CORE_LATENCY (L),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_state  (req_state),
    .req_key    (req_key),
    .core_state (core_state),
    .core_key   (core_key),
    .core_out   (core_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  // core stand-in: the FIPS-197 vector maps to its real ciphertext,
  // anything else to a cheap mixing function
  function automatic logic [127:0] core_fn(
    input logic [127:0] s,
    input logic [191:0] k
  );
    if (s == PT && k == KEY) return CT;
    return s ^ k[127:0] ^ {k[191:128], k[191:128]};
  endfunction

  logic [127:0] cpipe [L];
  always @(posedge clk) begin
    cpipe[0] <= core_fn(core_state, core_key);
    for (int k = 1; k < L; k++) cpipe[k] <= cpipe[k-1];
  end
  assign core_out = cpipe[L-1];

  typedef struct packed {
    logic [127:0] data;
    logic [1:0]   id;
  } exp_t;

  exp_t sbq[$];
  int   nchecks = 0;
  int   nerr    = 0;
  int   cyc     = 0;
  int   m_ptr   = 0;
  int   m_credit = DEPTH;
  int   acc_cnt = 0;
  int   last_acc = 0;
  int   ovf_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [191:0] got,
                     input logic [191:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  task automatic set_data(input int s);
    for (int i = 0; i < NREQ; i++) begin
      req_state[128*i +: 128] = {32'(s), 32'(i),
        32'hC0DE_0000 ^ 32'(s * 3), 32'(i * 7 + 1)};
      req_key[192*i +: 192] = {32'(s * 5), 32'hFACE_0000 + 32'(i),
        64'(s) << i, 64'h0123_4567_89AB_CDEF ^ 64'(s)};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue tracker: reference arbiter/credit model, pushes expectations
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int gi;
    logic acc;
    er = '0;
    gi = 0;
    acc = 1'b0;
    if (!rst_n) begin
      m_ptr = 0;
      m_credit = DEPTH;
      sbq.delete();
    end else begin
      chk("credit", 192'(dut.credit), 192'(m_credit));
      if (m_credit > 0) begin
        for (int k = 0; k < NREQ; k++) begin
          gi = (m_ptr + k) % NREQ;
          if (er == '0 && req_valid[gi]) er[gi] = 1'b1;
        end
      end
      chk("req_ready", 192'(req_ready), 192'(er));
      acc = |(req_valid & req_ready);
      if (acc) begin
        for (int i = 0; i < NREQ; i++)
          if (req_ready[i]) gi = i;
        sbq.push_back('{data: core_fn(req_state[128*gi +: 128],
                                      req_key[192*gi +: 192]),
                        id: 2'(gi)});
        m_ptr = (gi + 1) % NREQ;
        acc_cnt++;
        last_acc = cyc + 1;
      end
      if (rsp_valid && rsp_ready) m_credit++;
      if (acc) m_credit--;
      if (dut.fifo_full && dut.push && !dut.pop) ovf_cnt++;
    end
  end

  // response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL rsp_unexpected: got id %0d data %h, required none",
                 rsp_id, rsp_data);
      end else begin
        e = sbq.pop_front();
        chk("rsp_data", 192'(rsp_data), 192'(e.data));
        chk("rsp_id", 192'(rsp_id), 192'(e.id));
      end
    end
  end

  task automatic wait_idle();
    int k;
    rsp_ready = 1'b1;
    req_valid = '0;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_idle", 192'(k < 300), 192'(1));
    tick();
  endtask

  initial begin
    int tacc, tgot, ta, pc, stale, nv;
    rst_n     = 1'b0;
    req_valid = '0;
    req_state = '0;
    req_key   = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 192'(req_ready), 192'(0));
    chk("rst_rsp_valid", 192'(rsp_valid), 192'(0));
    chk("rst_busy", 192'(busy), 192'(0));
    chk("rst_core_state", 192'(core_state), 192'(0));
    chk("rst_core_key", core_key, 192'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_credit", 192'(dut.credit), 192'(DEPTH));
    tick();

    // single FIPS-197 block from requester 2
    rsp_ready = 1'b1;
    req_state[256 +: 128] = PT;
    req_key[384 +: 192] = KEY;
    req_valid = 4'b0100;
    tacc = -1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (req_ready[2]) begin
        tacc = cyc + 1;
        break;
      end
    end
    chk("t1_accept", 192'(tacc >= 0), 192'(1));
    tick();
    req_valid = '0;
    tgot = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        tgot = cyc;
        break;
      end
    end
    chk("t1_latency", 192'(tgot), 192'(tacc + L + 1));
    chk("t1_data", 192'(rsp_data), 192'(CT));
    chk("t1_id", 192'(rsp_id), 192'(2));
    @(negedge clk);
    chk("t1_busy_after_pop", 192'(busy), 192'(0));
    tick();

    // all requesters valid, consumer always ready
    ta = acc_cnt;
    for (int k = 0; k < 40; k++) begin
      set_data(100 + k);
      req_valid = '1;
      tick();
    end
    chk("t2_accepts", 192'(acc_cnt - ta), 192'(40));
    wait_idle();

    // backpressure: credits run out after exactly DEPTH accepts
    rsp_ready = 1'b0;
    ta = acc_cnt;
    for (int k = 0; k < 60; k++) begin
      set_data(200 + k);
      req_valid = '1;
      tick();
    end
    chk("t3_accepts_full", 192'(acc_cnt - ta), 192'(DEPTH));
    @(negedge clk);
    chk("t3_ready_zero", 192'(req_ready), 192'(0));
    tick();
    rsp_ready = 1'b1;
    ta = acc_cnt;
    tick();
    pc = cyc;
    rsp_ready = 1'b0;
    repeat (10) tick();
    chk("t3_one_more", 192'(acc_cnt - ta), 192'(1));
    chk("t4_accept_cycle", 192'(last_acc), 192'(pc + 1));
    chk("t4_credit_zero", 192'(dut.credit), 192'(0));
    wait_idle();

    // reset with 5 queued and 10 in flight
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_data(400 + k);
      req_valid = '1;
      tick();
    end
    req_valid = '0;
    repeat (L + 3) tick();
    for (int k = 0; k < 10; k++) begin
      set_data(500 + k);
      req_valid = '1;
      tick();
    end
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("t5_rsp_valid", 192'(rsp_valid), 192'(0));
    chk("t5_busy", 192'(busy), 192'(0));
    chk("t5_req_ready", 192'(req_ready), 192'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    stale = 0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("t5_stale", 192'(stale), 192'(0));
    chk("t5_credit", 192'(dut.credit), 192'(DEPTH));
    tick();

    // requester 1 alone, valid every other cycle
    ta = acc_cnt;
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      set_data(600 + k);
      req_valid = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      if (k % 2 == 0) nv++;
      tick();
    end
    chk("t6_accepts", 192'(acc_cnt - ta), 192'(nv));
    wait_idle();

    chk("no_overflow", 192'(ovf_cnt), 192'(0));
    chk("sb_empty", 192'(sbq.size()), 192'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerr);
    $finish;
  end

endmodule
